rasterizer_mem_arbiter: RTL and testbench

- Shares one Avalon-MM SDRAM master port among NUM_REQ pipeline requesters: vertex fetch, depth fetch and z-test writeback.
- Sits between the pipeline stage masters and the SDRAM controller. Closes the missing "write to SDRAM" path by funnelling all stage traffic through one port.
- Round-robin arbitration with a locked grant while the controller stalls.
- Pipelined reads; responses are routed back by a tag FIFO.

---
 rtl/rasterizer_pkg.sv | 23 ++
 rtl/rasterizer_mem_arbiter_arb_tag_fifo.sv | 59 +++++
 rtl/rasterizer_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rasterizer_mem_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the rasterizer memory arbiter.
// Requester ids are sized for the default three-port pipeline.
package rasterizer_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 26;
    localparam int unsigned NUM_REQ_DEFAULT = 3;
    localparam int unsigned REQ_ID_W        = $clog2(NUM_REQ_DEFAULT);

    localparam int unsigned REQ_VFETCH = 0;
    localparam int unsigned REQ_ZFETCH = 1;
    localparam int unsigned REQ_ZWRITE = 2;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Round-robin successor, wrapping at n requesters.
    function automatic req_id_t next_id(input req_id_t id, input int unsigned n);
        if (int'(id) + 1 >= int'(n)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/rasterizer_mem_arbiter_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each outstanding read, in issue order.
// Depth must be a power of two so the pointers wrap naturally.
module arb_tag_fifo
    import rasterizer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_id_t         mem_q [DEPTH];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == (PtrW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= push_id;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rasterizer_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among the pipeline stages.
// Optional performance counters are enabled with RASTER_ARB_PERF_EN.
module rasterizer_mem_arbiter
    import rasterizer_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*4-1:0]      req_byteenable,
    input  logic [NUM_REQ*32-1:0]     req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [31:0]               req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         master_address,
    output logic                      master_read,
    output logic                      master_write,
    output logic [3:0]                master_byteenable,
    output logic [31:0]               master_writedata,
    input  logic [31:0]               master_readdata,
    input  logic                      master_readdatavalid,
    input  logic                      master_waitrequest,
    output logic                      err_orphan_rdv
`ifdef RASTER_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]     perf_grant_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    logic [NUM_REQ-1:0] active;
    req_id_t            grant;
    logic               grant_vld;
    req_id_t            rr_ptr_q, rr_ptr_d;
    req_id_t            locked_q, locked_d;
    logic               lock_q, lock_d;
    logic               accept;
    logic               strobe;
    logic               err_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    req_id_t            fifo_head;

    assign active = req_read | req_write;

    // Grant: locked requester if a stalled transfer is pending, else first active from rr_ptr.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        if (lock_q) begin
            grant     = locked_q;
            grant_vld = active[locked_q];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (active[idx]) begin
                    grant     = req_id_t'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
        // Nothing is granted while reset is held.
        if (!reset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        master_address    = req_address[int'(grant)*ADDR_W +: ADDR_W];
        master_byteenable = req_byteenable[int'(grant)*4 +: 4];
        master_writedata  = req_writedata[int'(grant)*32 +: 32];
        master_read       = grant_vld & req_read[grant] & ~fifo_full;
        master_write      = grant_vld & req_write[grant] & ~req_read[grant];
        req_waitrequest   = '1;
        if (grant_vld) begin
            req_waitrequest[grant] = master_waitrequest | (req_read[grant] & fifo_full);
        end
    end

    assign strobe = master_read | master_write;
    assign accept = strobe & ~master_waitrequest;

    always_comb begin
        lock_d   = lock_q;
        locked_d = locked_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_id(grant, NUM_REQ);
        end else if (strobe) begin
            lock_d   = 1'b1;
            locked_d = grant;
        end else if (lock_q) begin
            // Locked requester withdrew its strobe; release the lock.
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_q   <= 1'b0;
            locked_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            lock_q   <= lock_d;
            locked_q <= locked_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign fifo_push = accept & master_read;
    assign fifo_pop  = master_readdatavalid & ~fifo_empty;

    arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (grant),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_comb begin
        req_readdata      = master_readdata;
        req_readdatavalid = '0;
        if (fifo_pop && reset) begin
            req_readdatavalid[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (master_readdatavalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_orphan_rdv = err_q;

`ifdef RASTER_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q;
    logic [31:0]              stall_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                grant_cnt_q[grant] <= grant_cnt_q[grant] + 32'd1;
            end
            if ((|active) && !accept) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Self-checking bench for rasterizer_mem_arbiter with a latency-modelled SDRAM controller
// and a scoreboard of expected read responses.
module tb_rasterizer_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 26;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ*ADDR_W-1:0] req_address = '0;
    logic [NUM_REQ-1:0]        req_read = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*4-1:0]      req_byteenable = '0;
    logic [NUM_REQ*32-1:0]     req_writedata = '0;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [31:0]               req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         master_address;
    logic                      master_read;
    logic                      master_write;
    logic [3:0]                master_byteenable;
    logic [31:0]               master_writedata;
    logic [31:0]               master_readdata = '0;
    logic                      master_readdatavalid = 1'b0;
    logic                      master_waitrequest = 1'b0;
    logic                      err_orphan_rdv;
`ifdef RASTER_ARB_PERF_EN
    logic [NUM_REQ*32-1:0]     perf_grant_cnt;
    logic [31:0]               perf_stall_cnt;
`endif

    rasterizer_mem_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .MAX_PENDING (8),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_address          (req_address),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_byteenable       (req_byteenable),
        .req_writedata        (req_writedata),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .err_orphan_rdv       (err_orphan_rdv)
`ifdef RASTER_ARB_PERF_EN
        ,
        .perf_grant_cnt       (perf_grant_cnt),
        .perf_stall_cnt       (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rsp_lat = 3;
    bit          rsp_en = 1'b1;
    bit          orphan_pulse = 1'b0;

    int          exp_id[$];
    logic [31:0] exp_data[$];
    logic [31:0] pend_data[$];
    int          pend_due[$];

    // Contents of the modelled SDRAM.
    function automatic logic [31:0] mem_data(input logic [ADDR_W-1:0] a);
        if (a == 26'h100) return 32'hDEADBEEF;
        return {6'd0, a} ^ 32'hA5A5_0000;
    endfunction

    // Negedge of a cycle: the controller model drives at most one read response.
    task automatic cyc_start();
        @(negedge clock);
        cyc++;
        if (orphan_pulse) begin
            master_readdatavalid = 1'b1;
            master_readdata      = 32'h1234_5678;
            orphan_pulse         = 1'b0;
        end else if (rsp_en && pend_data.size() > 0 && pend_due[0] <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = pend_data.pop_front();
            void'(pend_due.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = 32'h0;
        end
    endtask

    // Mid-cycle: scoreboard the response routing and capture reads the controller accepts.
    task automatic cyc_end();
        logic [2:0]  oh;
        logic [31:0] d;
        int          id;
        #1;
        if (master_readdatavalid) begin
            checks++;
            if (exp_id.size() == 0) begin
                if (req_readdatavalid !== 3'b000) begin
                    failures++;
                    $display("FAIL rsp_route: unexpected valid=%b at cycle %0d, want 000",
                             req_readdatavalid, cyc);
                end
            end else begin
                id = exp_id.pop_front();
                d  = exp_data.pop_front();
                oh = 3'b001 << id;
                if (req_readdatavalid !== oh || req_readdata !== d) begin
                    failures++;
                    $display("FAIL rsp_route: got valid=%b data=%h, want valid=%b data=%h",
                             req_readdatavalid, req_readdata, oh, d);
                end
            end
        end
        if (master_read && !master_waitrequest) begin
            pend_data.push_back(mem_data(master_address));
            pend_due.push_back(cyc + rsp_lat);
        end
    endtask

    task automatic apply_reset();
        exp_id.delete();
        exp_data.delete();
        pend_data.delete();
        pend_due.delete();
        cyc_start();
        reset = 1'b0;
        req_read = '0;
        req_write = '0;
        master_waitrequest = 1'b0;
        cyc_end();
        cyc_start();
        cyc_end();
        cyc_start();
        reset = 1'b1;
        cyc_end();
    endtask

    task automatic test_reset();
        cyc_start();
        req_read = 3'b111;
        req_address[1*ADDR_W +: ADDR_W] = 26'h55;
        #1;
        checks++;
        if (master_read !== 1'b0 || master_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: got rd=%b wr=%b, want 0 0", master_read, master_write);
        end
        checks++;
        if (req_waitrequest !== 3'b111) begin
            failures++;
            $display("FAIL reset_wait: got %b, want 111", req_waitrequest);
        end
        checks++;
        if (req_readdatavalid !== 3'b000 || err_orphan_rdv !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b err=%b, want 000 0",
                     req_readdatavalid, err_orphan_rdv);
        end
        cyc_end();
        req_read = '0;
        apply_reset();
    endtask

    task automatic test_single_read();
        int          got;
        logic [2:0]  rv;
        logic [31:0] rd;
        got = -1;
        rv  = '0;
        rd  = '0;
        cyc_start();
        req_read = 3'b010;
        req_address[1*ADDR_W +: ADDR_W] = 26'h100;
        #1;
        checks++;
        if (master_read !== 1'b1 || master_address !== 26'h100 || req_waitrequest !== 3'b101) begin
            failures++;
            $display("FAIL single_issue: got rd=%b addr=%h wait=%b, want 1 100 101",
                     master_read, master_address, req_waitrequest);
        end
        if (req_waitrequest[1] === 1'b0) begin
            exp_id.push_back(1);
            exp_data.push_back(mem_data(26'h100));
        end
        cyc_end();
        for (int k = 1; k <= 8; k++) begin
            cyc_start();
            req_read = '0;
            #1;
            if (k == 1) begin
                checks++;
                if (master_read !== 1'b0) begin
                    failures++;
                    $display("FAIL single_pulse: got rd=%b one cycle after issue, want 0",
                             master_read);
                end
            end
            if (req_readdatavalid !== 3'b000 && got < 0) begin
                got = k;
                rv  = req_readdatavalid;
                rd  = req_readdata;
            end
            cyc_end();
        end
        checks++;
        if (got !== 3 || rv !== 3'b010 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_rsp: got lat=%0d valid=%b data=%h, want 3 010 deadbeef",
                     got, rv, rd);
        end
    endtask

    task automatic test_rr_writes();
        logic [2:0] ew;
        int         g;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_address[i*ADDR_W +: ADDR_W] = 26'(32'h200 + i);
            req_writedata[i*32 +: 32]       = 32'hC0DE_0000 + i;
            req_byteenable[i*4 +: 4]        = 4'b0001 << i;
        end
        for (int n = 0; n < 6; n++) begin
            cyc_start();
            req_write = 3'b111;
            master_waitrequest = 1'b0;
            #1;
            g  = n % NUM_REQ;
            ew = ~(3'b001 << g);
            checks++;
            if (master_write !== 1'b1 || master_read !== 1'b0
                || master_address !== 26'(32'h200 + g)
                || master_writedata !== 32'hC0DE_0000 + g
                || master_byteenable !== 4'(4'b0001 << g) || req_waitrequest !== ew) begin
                failures++;
                $display("FAIL rr_write[%0d]: got addr=%h data=%h be=%b wait=%b, want grant %0d",
                         n, master_address, master_writedata, master_byteenable,
                         req_waitrequest, g);
            end
            cyc_end();
        end
        cyc_start();
        req_write = '0;
        cyc_end();
    endtask

    task automatic test_lock();
        logic [2:0] ew;
        req_address[0*ADDR_W +: ADDR_W] = 26'h400;
        req_address[2*ADDR_W +: ADDR_W] = 26'h402;
        req_writedata[0*32 +: 32]       = 32'h0000_AAAA;
        req_writedata[2*32 +: 32]       = 32'h2222_BBBB;
        for (int k = 1; k <= 5; k++) begin
            cyc_start();
            req_write = (k == 1) ? 3'b100 : 3'b101;
            master_waitrequest = (k < 5);
            #1;
            ew = (k < 5) ? 3'b111 : 3'b011;
            checks++;
            if (master_write !== 1'b1 || master_address !== 26'h402
                || master_writedata !== 32'h2222_BBBB || req_waitrequest !== ew) begin
                failures++;
                $display("FAIL lock_hold[%0d]: got wr=%b addr=%h data=%h wait=%b, want 1 402 2222bbbb %b",
                         k, master_write, master_address, master_writedata, req_waitrequest, ew);
            end
            cyc_end();
        end
        cyc_start();
        req_write = 3'b101;
        master_waitrequest = 1'b0;
        #1;
        checks++;
        if (master_address !== 26'h400 || master_writedata !== 32'h0000_AAAA
            || req_waitrequest !== 3'b110) begin
            failures++;
            $display("FAIL lock_release: got addr=%h data=%h wait=%b, want 400 0000aaaa 110",
                     master_address, master_writedata, req_waitrequest);
        end
        cyc_end();
        cyc_start();
        req_write = '0;
        cyc_end();
    endtask

    task automatic test_fifo_full();
        int n_acc;
        n_acc = 0;
        apply_reset();
        rsp_en = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc_start();
            req_read = 3'b001;
            req_address[0*ADDR_W +: ADDR_W] = 26'(32'h1000 + n_acc);
            #1;
            checks++;
            if (c < 8) begin
                if (master_read !== 1'b1 || req_waitrequest[0] !== 1'b0
                    || master_address !== 26'(32'h1000 + c)) begin
                    failures++;
                    $display("FAIL fill[%0d]: got rd=%b wait=%b addr=%h, want 1 0 %h",
                             c, master_read, req_waitrequest[0], master_address, 32'h1000 + c);
                end
            end else if (master_read !== 1'b0 || req_waitrequest[0] !== 1'b1) begin
                failures++;
                $display("FAIL full_stall[%0d]: got rd=%b wait=%b, want 0 1",
                         c, master_read, req_waitrequest[0]);
            end
            if (req_waitrequest[0] === 1'b0) begin
                exp_id.push_back(0);
                exp_data.push_back(mem_data(26'(32'h1000 + n_acc)));
                n_acc++;
            end
            cyc_end();
        end
        checks++;
        if (n_acc !== 8) begin
            failures++;
            $display("FAIL full_count: got %0d accepted, want 8", n_acc);
        end
        rsp_en = 1'b1;
        cyc_start();
        #1;
        checks++;
        if (master_read !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_cycle: got rd=%b while popping, want 0", master_read);
        end
        cyc_end();
        cyc_start();
        #1;
        checks++;
        if (master_read !== 1'b1 || req_waitrequest[0] !== 1'b0 || master_address !== 26'h1008) begin
            failures++;
            $display("FAIL full_resume: got rd=%b wait=%b addr=%h, want 1 0 1008",
                     master_read, req_waitrequest[0], master_address);
        end
        if (req_waitrequest[0] === 1'b0) begin
            exp_id.push_back(0);
            exp_data.push_back(mem_data(26'h1008));
        end
        cyc_end();
        for (int k = 0; k < 20 && exp_id.size() > 0; k++) begin
            cyc_start();
            req_read = '0;
            cyc_end();
        end
        req_read = '0;
        checks++;
        if (exp_id.size() != 0) begin
            failures++;
            $display("FAIL full_drain: got %0d responses missing, want 0", exp_id.size());
        end
    endtask

    task automatic test_interleave();
        int         who[3];
        logic [2:0] seen[3];
        logic [2:0] want[3];
        int         n;
        who  = '{0, 1, 0};
        want = '{3'b001, 3'b010, 3'b001};
        seen = '{3'b000, 3'b000, 3'b000};
        n    = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cyc_start();
            req_read = 3'b001 << who[i];
            req_address[who[i]*ADDR_W +: ADDR_W] = 26'(32'h300 + i);
            #1;
            if (req_waitrequest[who[i]] === 1'b0) begin
                exp_id.push_back(who[i]);
                exp_data.push_back(mem_data(26'(32'h300 + i)));
            end
            cyc_end();
        end
        for (int k = 0; k < 12; k++) begin
            cyc_start();
            req_read = '0;
            #1;
            if (req_readdatavalid !== 3'b000 && n < 3) begin
                seen[n] = req_readdatavalid;
                n++;
            end
            cyc_end();
        end
        checks++;
        if (n !== 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2]) begin
            failures++;
            $display("FAIL interleave: got %0d rsp %b %b %b, want 3 rsp 001 010 001",
                     n, seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_orphan();
        apply_reset();
        cyc_start();
        #1;
        checks++;
        if (err_orphan_rdv !== 1'b0) begin
            failures++;
            $display("FAIL orphan_pre: got err=%b, want 0", err_orphan_rdv);
        end
        cyc_end();
        orphan_pulse = 1'b1;
        cyc_start();
        #1;
        checks++;
        if (req_readdatavalid !== 3'b000) begin
            failures++;
            $display("FAIL orphan_valid: got %b, want 000", req_readdatavalid);
        end
        cyc_end();
        for (int k = 0; k < 3; k++) begin
            cyc_start();
            #1;
            checks++;
            if (err_orphan_rdv !== 1'b1) begin
                failures++;
                $display("FAIL orphan_sticky[%0d]: got err=%b, want 1", k, err_orphan_rdv);
            end
            cyc_end();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_lock();
        test_fifo_full();
        test_interleave();
        test_orphan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
